// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU select sequencer and the result mux.
//   - select-code constants driven on alu_sel
//   - funct3 operation-class constants used by the decoder
//   - sequencer FSM state type
package alu_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned F3_W  = 3;

    localparam logic [SEL_W-1:0] ALU_SEL_ADD = 3'b000;
    localparam logic [SEL_W-1:0] ALU_SEL_SUB = 3'b001;
    localparam logic [SEL_W-1:0] ALU_SEL_AND = 3'b010;
    localparam logic [SEL_W-1:0] ALU_SEL_XOR = 3'b011;
    localparam logic [SEL_W-1:0] ALU_SEL_SLT = 3'b101;

    localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
    localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
    localparam logic [F3_W-1:0] F3_AND     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_sel_decode.sv
// alu_sel_decode: combinational {funct3, funct7b5} -> ALU select code.
// Ports:
//   funct3    in  3  operation class
//   funct7b5  in  1  operation modifier (sub vs add)
//   sel_c     out 3  decoded select; ADD for illegal combinations
//   illegal_c out 1  combination is not a supported operation
module alu_sel_decode
    import alu_pkg::*;
(
    input  logic [F3_W-1:0]  funct3,
    input  logic             funct7b5,
    output logic [SEL_W-1:0] sel_c,
    output logic             illegal_c
);

    // Only the five listed encodings are legal; everything else falls back to ADD.
    always_comb begin
        sel_c     = ALU_SEL_ADD;
        illegal_c = 1'b0;
        case ({funct3, funct7b5})
            {F3_ADD_SUB, 1'b0}: sel_c = ALU_SEL_ADD;
            {F3_ADD_SUB, 1'b1}: sel_c = ALU_SEL_SUB;
            {F3_AND,     1'b0}: sel_c = ALU_SEL_AND;
            {F3_XOR,     1'b0}: sel_c = ALU_SEL_XOR;
            {F3_SLT,     1'b0}: sel_c = ALU_SEL_SLT;
            default:            illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sel_sequencer.sv
// alu_sel_sequencer: accepts one ALU command at a time, drives operands and
// select into the ALU datapath, waits ALU_LAT cycles, captures the muxed
// result and returns it on a valid/ready response channel.
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN -- illegal commands are
// answered after one cycle with rsp_err=1, rsp_data=0 and no datapath update.
// Without it, illegal commands execute as ADD and rsp_err stays 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_funct3, cmd_funct7b5 operation fields
//   cmd_a, cmd_b             operands
//   alu_a, alu_b, alu_sel    registered drive into the ALU datapath
//   alu_result               muxed result from the datapath
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_err        captured result, illegal-command flag
module alu_sel_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_funct3,
    input  logic             cmd_funct7b5,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_sel,
    input  logic [N-1:0]     alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             rsp_err
);

    localparam int unsigned        CNT_W    = 4;
    localparam logic [CNT_W-1:0]   LAT_LAST = CNT_W'(ALU_LAT - 1);

    seq_state_t        state, state_next;
    logic [CNT_W-1:0]  lat_cnt, lat_cnt_next;
    logic [N-1:0]      alu_a_next, alu_b_next, rsp_data_next;
    logic [SEL_W-1:0]  alu_sel_next;
    logic              rsp_valid_next, rsp_err_next;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_illegal;
    logic              cmd_fire;

    alu_sel_decode u_decode (
        .funct3    (cmd_funct3),
        .funct7b5  (cmd_funct7b5),
        .sel_c     (dec_sel),
        .illegal_c (dec_illegal)
    );

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic trap_pend, trap_pend_next;
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    // cmd_ready is a registered copy of "state is IDLE", so it must gate acceptance.
    assign cmd_fire = cmd_valid && cmd_ready;

    // Next-state and next-register logic.
    always_comb begin
        state_next     = state;
        lat_cnt_next   = lat_cnt;
        alu_a_next     = alu_a;
        alu_b_next     = alu_b;
        alu_sel_next   = alu_sel;
        rsp_valid_next = rsp_valid;
        rsp_data_next  = rsp_data;
        rsp_err_next   = rsp_err;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        trap_pend_next = trap_pend;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    lat_cnt_next = '0;
                    state_next   = ST_EXEC;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    // Illegal ops pass once through EXEC untouched so the
                    // error response appears one edge after acceptance.
                    trap_pend_next = dec_illegal;
                    if (!dec_illegal) begin
                        alu_a_next   = cmd_a;
                        alu_b_next   = cmd_b;
                        alu_sel_next = dec_sel;
                    end
`else
                    alu_a_next   = cmd_a;
                    alu_b_next   = cmd_b;
                    alu_sel_next = dec_sel;
`endif
                end
            end
            ST_EXEC: begin
                lat_cnt_next = lat_cnt + 4'd1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                if (trap_pend) begin
                    trap_pend_next = 1'b0;
                    rsp_data_next  = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RESP;
                end else
`endif
                if (lat_cnt == LAT_LAST) begin
                    rsp_data_next  = alu_result;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == ST_IDLE);
        end
    end

    // Datapath and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= ALU_SEL_ADD;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            lat_cnt   <= lat_cnt_next;
            alu_a     <= alu_a_next;
            alu_b     <= alu_b_next;
            alu_sel   <= alu_sel_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
            rsp_err   <= rsp_err_next;
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    // Pending-trap flag for an accepted illegal command.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_pend <= 1'b0;
        end else begin
            trap_pend <= trap_pend_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sel_sequencer.sv
// tb_alu_sel_sequencer: directed stimulus with a response scoreboard.
// Stimulus pushes the expected response; a negedge monitor pops and compares
// on every accepted response. A simple ALU model closes the datapath loop.
module tb_alu_sel_sequencer;

    localparam int unsigned N   = 32;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_funct3;
    logic          cmd_funct7b5;
    logic [N-1:0]  cmd_a, cmd_b;
    logic [N-1:0]  alu_a, alu_b;
    logic [2:0]    alu_sel;
    logic [N-1:0]  alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          rsp_err;

    typedef struct {
        logic [N-1:0] data;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rsp_cnt  = 0;

    alu_sel_sequencer #(.N(N), .ALU_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_funct3   (cmd_funct3),
        .cmd_funct7b5 (cmd_funct7b5),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    // ALU datapath model driven by the sequencer's registered outputs.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = 32'($signed(alu_a) < $signed(alu_b));
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare every accepted response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got data 0x%08h err %0d expected no response", rsp_data, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Present a command and hold it until accepted; returns at T+#1.
    task automatic send(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd_funct3   = f3;
        cmd_funct7b5 = f7;
        cmd_a        = a;
        cmd_b        = b;
        cmd_valid    = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Count edges from acceptance until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 32) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Checks after acceptance with rsp_ready held high.
    task automatic finish_op(input logic [2:0] exp_sel, input int exp_lat);
        int lat;
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        chk("alu_sel", 32'(alu_sel), 32'(exp_sel));
        wait_rsp(lat);
        chk("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        chk("cmd_ready_return", 32'(cmd_ready), 32'd1);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input logic exp_err, input logic [2:0] exp_sel,
                          input int exp_lat);
        exp_q.push_back('{exp_data, exp_err});
        send(f3, f7, a, b);
        finish_op(exp_sel, exp_lat);
    endtask

    logic [2:0]  op_f3  [5] = '{3'b000, 3'b000, 3'b111, 3'b100, 3'b010};
    logic        op_f7  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  op_sel [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    logic [31:0] op_res [5] = '{32'h0000_0FFF, 32'hFFFF_F1E1, 32'h0000_0000, 32'h0000_0FFF, 32'h0000_0001};

    initial begin
        int lat;
        int n0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_funct3   = 3'b000;
        cmd_funct7b5 = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        rsp_ready    = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Subtract 10 - 3
        run_op(3'b000, 1'b1, 32'd10, 32'd3, 32'd7, 1'b0, 3'b001, LAT);

        // All five legal ops back to back
        for (int i = 0; i < 5; i++)
            run_op(op_f3[i], op_f7[i], 32'h0000_00F0, 32'h0000_0F0F, op_res[i], 1'b0, op_sel[i], LAT);

        // Backpressure: response held for 5 cycles
        rsp_ready = 1'b0;
        n0 = rsp_cnt;
        exp_q.push_back('{32'h0000_5678, 1'b0});
        send(3'b111, 1'b0, 32'h1234_5678, 32'h0000_FFFF);
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 32'(LAT));
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_data_hold", rsp_data, 32'h0000_5678);
            chk("bp_rsp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        chk("bp_no_early_accept", 32'(rsp_cnt - n0), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_accepted_once", 32'(rsp_cnt - n0), 32'd1);
        chk("bp_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("bp_cmd_ready_return", 32'(cmd_ready), 32'd1);

        // Illegal funct3=001 (previous select was AND)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        run_op(3'b001, 1'b0, 32'd5, 32'd6, 32'd0, 1'b1, 3'b010, 1);
        chk("trap_alu_a_kept", alu_a, 32'h1234_5678);
`else
        run_op(3'b001, 1'b0, 32'd5, 32'd6, 32'd11, 1'b0, 3'b000, LAT);
`endif

        // Reset during EXEC discards the command
        n0 = rsp_cnt;
        send(3'b000, 1'b1, 32'd100, 32'd20);
        chk("exec_before_rst_sel", 32'(alu_sel), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_rsp", 32'(rsp_cnt - n0), 32'd0);
        chk("rst_rsp_valid_idle", 32'(rsp_valid), 32'd0);

        // New command held during RESP waits for IDLE
        rsp_ready = 1'b0;
        exp_q.push_back('{32'hA5A5_0F0F, 1'b0});
        send(3'b100, 1'b0, 32'hAAAA_0000, 32'h0F0F_0F0F);
        wait_rsp(lat);
        chk("hold_latency", 32'(lat), 32'(LAT));
        exp_q.push_back('{32'h0000_0123, 1'b0});
        @(negedge clk);
        cmd_funct3   = 3'b000;
        cmd_funct7b5 = 1'b0;
        cmd_a        = 32'h0000_0100;
        cmd_b        = 32'h0000_0023;
        cmd_valid    = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("hold_cmd_ready_low", 32'(cmd_ready), 32'd0);
            chk("hold_alu_a_kept", alu_a, 32'hAAAA_0000);
            chk("hold_rsp_data", rsp_data, 32'hA5A5_0F0F);
        end
        rsp_ready = 1'b1;
        send(3'b000, 1'b0, 32'h0000_0100, 32'h0000_0023);
        chk("hold_second_alu_a", alu_a, 32'h0000_0100);
        finish_op(3'b000, LAT);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("rsp_total", 32'(rsp_cnt), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sel_sequencer.md
# alu_sel_sequencer

Command-side controller for the ALU result mux. It accepts an operation command (funct3, funct7 bit 5, two operands) over a valid/ready handshake and decodes the funct fields into the 3-bit ALU select code. It then drives operands and select into the ALU datapath, waits a configurable number of cycles, captures the muxed result, and returns it over a valid/ready response channel. It sits between instruction issue and the ALU/result-mux datapath and is the sole producer of the select code.

## Interface
- N, 32, operand/result width
- ALU_LAT, 1, cycles from operand/select drive to a valid `alu_result`; legal range 1..15
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_funct3  in  3  operation class
- cmd_funct7b5  in  1  operation modifier (sub vs add)
- cmd_a, cmd_b  in  N  operands
- alu_a, alu_b  out  N  registered operands to the datapath
- alu_sel  out  3  registered select to the result mux
- alu_result  in  N  muxed ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  N  captured result
- rsp_err  out  1  command was illegal

## Operation
- Decode uses {funct3, funct7b5} -> alu_sel:
  - 000/0 -> 000 add
  - 000/1 -> 001 sub
  - 111/0 -> 010 and
  - 100/0 -> 011 xor
  - 010/0 -> 101 slt
  - every other combination is illegal
- The legal select codes are therefore exactly 000, 001, 010, 011 and 101; the sequencer never drives 100, 110 or 111.
- FSM states are IDLE, EXEC and RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, register `cmd_a`/`cmd_b` into `alu_a`/`alu_b`, register the decoded select into `alu_sel`, clear `lat_cnt`, and go to EXEC. The illegal-op exception is described under Configuration.
- EXEC: `lat_cnt` increments each cycle. When `lat_cnt`==ALU_LAT-1, capture `alu_result` into `rsp_data`, set `rsp_valid`=1 and `rsp_err`=0, and go to RESP.
- RESP: hold `rsp_data`, `rsp_err` and `rsp_valid` stable. On `rsp_ready`, clear `rsp_valid` and go to IDLE.
- `alu_a`, `alu_b` and `alu_sel` hold their last values outside EXEC; they are not cleared.
- Only one command is outstanding at a time; there is no buffering.
- `lat_cnt` is 4 bits wide and cannot wrap within the legal ALU_LAT range.

## Timing
- Reset values: `cmd_ready`=0 while `rst`=1, and 1 in the first cycle after reset releases (state IDLE). `alu_a`=0, `alu_b`=0, `alu_sel`=000, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `lat_cnt`=0.
- `cmd_ready` is a decode of state==IDLE. It does not depend combinationally on `cmd_valid`.
- Latency:
  - A command accepted at edge T reaches `alu_*` at T.
  - `rsp_valid` rises at edge T+ALU_LAT.
  - With `rsp_ready` held at 1, `cmd_ready` returns at T+ALU_LAT+1.
  - Minimum issue interval is ALU_LAT+1 cycles.
- `rsp_valid` and `rsp_ready` in the same cycle as entering RESP: not possible, because `rsp_valid` becomes visible only in RESP. The acceptance cycle is the first RESP cycle with `rsp_ready`=1.
- `rst` asserted in any state returns to IDLE at the next edge with reset values. An in-flight command and any pending response are discarded.
- `cmd_valid` asserted in EXEC or RESP is ignored (`cmd_ready`=0). The command must be held by the producer.

## Configuration
- Macro: `ALU_SEQ_ILLEGAL_TRAP_EN`.
- Defined:
  - An illegal command is accepted in IDLE and goes directly to RESP at the next edge.
  - `rsp_err`=1, `rsp_data`=0.
  - `alu_a`, `alu_b` and `alu_sel` are not updated.
  - Response latency is 1 cycle.
- Undefined:
  - An illegal command decodes to `alu_sel`=000 (add) and runs through EXEC like a legal one.
  - `rsp_err` is tied to 0.

## Structure
- Shared package `alu_pkg`:
  - Select-code localparams ALU_SEL_ADD=000, ALU_SEL_SUB=001, ALU_SEL_AND=010, ALU_SEL_XOR=011, ALU_SEL_SLT=101.
  - Funct3 constants.
  - FSM state enum typedef.
  - The same package is used by the result mux.
- One sub-module, `alu_sel_decode`: combinational {funct3, funct7b5} -> {sel[2:0], illegal}.

## Test plan
- After reset, sub with a=10, b=3, ALU_LAT=2, bench models the ALU -> `alu_sel`=001 at T; `rsp_valid` at T+2 with `rsp_data`=7, `rsp_err`=0.
- All five legal ops back-to-back, a=0x0000_00F0, b=0x0000_0F0F -> selects 000/001/010/011/101 and results 0xFFF, 0xFFFF_F1E1, 0x0, 0xFFF, 1 (slt signed).
- Backpressure: `rsp_ready`=0 for 5 cycles -> `rsp_data` stable, `cmd_ready`=0 throughout; accepted on the first `rsp_ready`=1 cycle.
- Illegal funct3=001 with `ALU_SEQ_ILLEGAL_TRAP_EN` -> `rsp_valid` at T+1, `rsp_err`=1, `rsp_data`=0, `alu_sel` unchanged. Without the macro -> add executed, `rsp_err`=0.
- `rst` pulsed during EXEC -> next cycle `cmd_ready`=1, `rsp_valid`=0, `alu_sel`=000; no response is ever emitted for that command.
- `cmd_valid` held during RESP with a new command -> not accepted until IDLE; the second response carries the second command's result.
